// File: rtl/controller_bist.sv
// ---------------------------------------------------------------------------
// controller_bist
//
// Built-in self-test driver for the big_controller main decoder. A start
// request walks the decoder's opcode input through an 11-entry vector table.
// After a programmable settle delay each decoder response is compared with a
// golden control word. The block accumulates the number of failing vectors,
// the index of the first failing vector and an OR of all bit differences.
//
// Parameters
//   SETTLE            cycles from an opcode change to its sample point (1..15)
//
// Ports
//   clk_i             system clock, rising edge
//   rst_ni            asynchronous active-low reset
//   start_i           begin a run (honoured only in IDLE or DONE)
//   ctrl_word_i[14:0] decoder outputs {r_type, alu_src, mem_to_reg, reg_write,
//                     reg_write2, mem_read, mem_write, j, jal, beq, bne, ori,
//                     lui, alu_op[1:0]}
//   opcode_o[5:0]     opcode driven to the decoder
//   busy_o            run in progress (WAIT or CHECK)
//   done_o            run complete, results held
//   pass_o            run complete with no failing vector
//   fail_count_o[3:0] number of failing vectors
//   first_fail_idx_o  index of the first failing vector, 4'hF if none
//   fail_bits_o[14:0] OR-accumulation of (ctrl_word_i ^ golden)
// ---------------------------------------------------------------------------
module controller_bist #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [14:0] ctrl_word_i,
  output logic [5:0]  opcode_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [3:0]  fail_count_o,
  output logic [3:0]  first_fail_idx_o,
  output logic [14:0] fail_bits_o
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StCheck,
    StDone
  } state_e;

  localparam logic [3:0] LastIdx   = 4'd10;
  localparam logic [3:0] NoFail    = 4'hF;
  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  // Opcode stimulus table, indexed by vector number.
  function automatic logic [5:0] vecOpcode(input logic [3:0] idx);
    logic [5:0] op;
    case (idx)
      4'd0:    op = 6'b000000;  // R-type
      4'd1:    op = 6'b100011;  // lw
      4'd2:    op = 6'b101011;  // sw
      4'd3:    op = 6'b000100;  // beq
      4'd4:    op = 6'b000101;  // bne
      4'd5:    op = 6'b000010;  // j
      4'd6:    op = 6'b000011;  // jal
      4'd7:    op = 6'b001101;  // ori
      4'd8:    op = 6'b001111;  // lui
      4'd9:    op = 6'b001000;  // addi
      default: op = 6'b111111;  // unsupported
    endcase
    return op;
  endfunction

  // Golden control words. Bit map: 14 r_type, 13 alu_src, 12 mem_to_reg,
  // 11 reg_write, 10 reg_write2, 9 mem_read, 8 mem_write, 7 j, 6 jal,
  // 5 beq, 4 bne, 3 ori, 2 lui, 1:0 alu_op.
  function automatic logic [14:0] vecGolden(input logic [3:0] idx);
    logic [14:0] gold;
    case (idx)
      4'd0:    gold = 15'h4C03;  // r_type, reg_write, reg_write2, alu_op=11
      4'd1:    gold = 15'h3A00;  // alu_src, mem_to_reg, reg_write, mem_read
      4'd2:    gold = 15'h2100;  // alu_src, mem_write
      4'd3:    gold = 15'h0021;  // beq, alu_op=01
      4'd4:    gold = 15'h0011;  // bne, alu_op=01
      4'd5:    gold = 15'h0080;  // j
      4'd6:    gold = 15'h0840;  // jal, reg_write
      4'd7:    gold = 15'h280A;  // alu_src, reg_write, ori, alu_op=10
      4'd8:    gold = 15'h2804;  // alu_src, reg_write, lui
      4'd9:    gold = 15'h2800;  // alu_src, reg_write
      default: gold = 15'h0000;  // unsupported opcode decodes to nothing
    endcase
    return gold;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [3:0]  failCount_q, failCount_d;
  logic [3:0]  firstFail_q, firstFail_d;
  logic [14:0] failBits_q, failBits_d;

  logic [14:0] diff;

  assign diff = ctrl_word_i ^ vecGolden(idx_q);

  // State and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      idx_q       <= 4'd0;
      cnt_q       <= 4'd0;
      opcode_q    <= 6'b000000;
      failCount_q <= 4'd0;
      firstFail_q <= NoFail;
      failBits_q  <= 15'h0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      failCount_q <= failCount_d;
      firstFail_q <= firstFail_d;
      failBits_q  <= failBits_d;
    end
  end

  // Next-state logic. Each vector spends SETTLE cycles in WAIT and one in
  // CHECK, so the sample lands SETTLE+1 edges after the opcode change.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    failCount_d = failCount_q;
    firstFail_d = firstFail_q;
    failBits_d  = failBits_q;

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          failCount_d = 4'd0;
          failBits_d  = 15'h0000;
          firstFail_d = NoFail;
          idx_d       = 4'd0;
          opcode_d    = vecOpcode(4'd0);
          cnt_d       = SettleCnt;
          state_d     = StWait;
        end
      end

      StWait: begin
        // Treat 0 like 1 so a mis-set counter can never stall the run.
        if (cnt_q <= 4'd1) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StCheck: begin
        if (diff != 15'h0000) begin
          failCount_d = failCount_q + 4'd1;
          failBits_d  = failBits_q | diff;
          if (firstFail_q == NoFail) begin
            firstFail_d = idx_q;
          end
        end
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d    = idx_q + 4'd1;
          opcode_d = vecOpcode(idx_q + 4'd1);
          cnt_d    = SettleCnt;
          state_d  = StWait;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign opcode_o         = opcode_q;
  assign busy_o           = (state_q == StWait) || (state_q == StCheck);
  assign done_o           = (state_q == StDone);
  assign pass_o           = (state_q == StDone) && (failCount_q == 4'd0);
  assign fail_count_o     = failCount_q;
  assign first_fail_idx_o = firstFail_q;
  assign fail_bits_o      = failBits_q;

endmodule

// File: tb/tb_controller_bist.sv
// ---------------------------------------------------------------------------
// tb_controller_bist
//
// Directed bench for controller_bist. Three instances share clock and reset:
//   A: SETTLE=1 against a combinational decoder model with injectable faults
//   B: SETTLE=4 against a decoder model with 3 cycles of output latency
//   C: SETTLE=2 against the same kind of 3-cycle-latency decoder
// ---------------------------------------------------------------------------
module tb_controller_bist;

  logic clk = 1'b0;
  logic rst_n;
  logic startA, startB, startC;
  logic [1:0] faultMode;

  logic [14:0] ctrlA, ctrlB, ctrlC;
  logic [5:0]  opA, opB, opC;
  logic        busyA, busyB, busyC;
  logic        doneA, doneB, doneC;
  logic        passA, passB, passC;
  logic [3:0]  failCountA, failCountB, failCountC;
  logic [3:0]  firstFailA, firstFailB, firstFailC;
  logic [14:0] failBitsA, failBitsB, failBitsC;

  logic [14:0] pipeB1, pipeB2, pipeB3;
  logic [14:0] pipeC1, pipeC2, pipeC3;

  int checks = 0;
  int failures = 0;
  int n;

  logic [5:0] vecOps [0:10];

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Reference decoder built field by field from the opcode.
  function automatic logic [14:0] refDecode(input logic [5:0] op);
    logic rType, aluSrc, memToReg, regWrite, regWrite2, memRead, memWrite;
    logic jmp, jal, beq, bne, ori, lui;
    logic [1:0] aluOp;
    {rType, aluSrc, memToReg, regWrite, regWrite2, memRead, memWrite} = '0;
    {jmp, jal, beq, bne, ori, lui} = '0;
    aluOp = 2'b00;
    case (op)
      6'b000000: begin rType = 1'b1; regWrite = 1'b1; regWrite2 = 1'b1; aluOp = 2'b11; end
      6'b100011: begin aluSrc = 1'b1; memToReg = 1'b1; regWrite = 1'b1; memRead = 1'b1; end
      6'b101011: begin aluSrc = 1'b1; memWrite = 1'b1; end
      6'b000100: begin beq = 1'b1; aluOp = 2'b01; end
      6'b000101: begin bne = 1'b1; aluOp = 2'b01; end
      6'b000010: begin jmp = 1'b1; end
      6'b000011: begin jal = 1'b1; regWrite = 1'b1; end
      6'b001101: begin aluSrc = 1'b1; regWrite = 1'b1; ori = 1'b1; aluOp = 2'b10; end
      6'b001111: begin aluSrc = 1'b1; regWrite = 1'b1; lui = 1'b1; end
      6'b001000: begin aluSrc = 1'b1; regWrite = 1'b1; end
      default: ;
    endcase
    return {rType, aluSrc, memToReg, regWrite, regWrite2, memRead, memWrite,
            jmp, jal, beq, bne, ori, lui, aluOp};
  endfunction

  // Decoder A: mode 1 forces ori low, mode 2 holds alu_op at 11.
  always_comb begin
    ctrlA = refDecode(opA);
    if (faultMode == 2'd1) ctrlA = ctrlA & ~15'h0008;
    else if (faultMode == 2'd2) ctrlA = ctrlA | 15'h0003;
  end

  // Decoders B and C register their outputs through three stages.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipeB1 <= '0; pipeB2 <= '0; pipeB3 <= '0;
      pipeC1 <= '0; pipeC2 <= '0; pipeC3 <= '0;
    end else begin
      pipeB1 <= refDecode(opB); pipeB2 <= pipeB1; pipeB3 <= pipeB2;
      pipeC1 <= refDecode(opC); pipeC2 <= pipeC1; pipeC3 <= pipeC2;
    end
  end
  assign ctrlB = pipeB3;
  assign ctrlC = pipeC3;

  controller_bist #(.SETTLE(1)) dutA (
    .clk_i(clk), .rst_ni(rst_n), .start_i(startA), .ctrl_word_i(ctrlA),
    .opcode_o(opA), .busy_o(busyA), .done_o(doneA), .pass_o(passA),
    .fail_count_o(failCountA), .first_fail_idx_o(firstFailA), .fail_bits_o(failBitsA)
  );

  controller_bist #(.SETTLE(4)) dutB (
    .clk_i(clk), .rst_ni(rst_n), .start_i(startB), .ctrl_word_i(ctrlB),
    .opcode_o(opB), .busy_o(busyB), .done_o(doneB), .pass_o(passB),
    .fail_count_o(failCountB), .first_fail_idx_o(firstFailB), .fail_bits_o(failBitsB)
  );

  controller_bist #(.SETTLE(2)) dutC (
    .clk_i(clk), .rst_ni(rst_n), .start_i(startC), .ctrl_word_i(ctrlC),
    .opcode_o(opC), .busy_o(busyC), .done_o(doneC), .pass_o(passC),
    .fail_count_o(failCountC), .first_fail_idx_o(firstFailC), .fail_bits_o(failBitsC)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start on the selected instance for exactly one edge (E0).
  task automatic applyStimulus(input int which);
    case (which)
      0: startA = 1'b1;
      1: startB = 1'b1;
      default: startC = 1'b1;
    endcase
    tick();
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
  endtask

  function automatic logic doneOf(input int which);
    case (which)
      0: return doneA;
      1: return doneB;
      default: return doneC;
    endcase
  endfunction

  // Count edges until done, starting from edgesSoFar; bounded by budget.
  task automatic waitDone(input int which, input int edgesSoFar, input int budget, output int edges);
    edges = edgesSoFar;
    while (!doneOf(which) && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    vecOps = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
               6'b000011, 6'b001101, 6'b001111, 6'b001000, 6'b111111};
    rst_n = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
    faultMode = 2'd0;
    #22;

    // Reset values.
    checkOutput("rst_opcode", opA, 6'b000000);
    checkOutput("rst_busy", busyA, 1'b0);
    checkOutput("rst_done", doneA, 1'b0);
    checkOutput("rst_pass", passA, 1'b0);
    checkOutput("rst_fail_count", failCountA, 4'd0);
    checkOutput("rst_first_fail", firstFailA, 4'hF);
    checkOutput("rst_fail_bits", failBitsA, 15'h0000);
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("idle_busy", busyA, 1'b0);

    // Golden run, SETTLE=1: each opcode held two cycles, done after E22.
    $display("[TB] golden run with exact timing");
    applyStimulus(0);
    checkOutput("run_busy", busyA, 1'b1);
    checkOutput("op_seq_0", opA, vecOps[0]);
    for (int j = 1; j < 22; j++) begin
      tick();
      checkOutput($sformatf("op_seq_%0d", j), opA, vecOps[j / 2]);
      checkOutput($sformatf("done_early_%0d", j), doneA, 1'b0);
    end
    tick();
    checkOutput("gold_done", doneA, 1'b1);
    checkOutput("gold_pass", passA, 1'b1);
    checkOutput("gold_busy", busyA, 1'b0);
    checkOutput("gold_fail_count", failCountA, 4'd0);
    checkOutput("gold_first_fail", firstFailA, 4'hF);
    checkOutput("gold_fail_bits", failBitsA, 15'h0000);
    checkOutput("gold_opcode_hold", opA, 6'b111111);

    // ori forced low: only vector 7 fails.
    $display("[TB] ori stuck-at-0 run");
    faultMode = 2'd1;
    applyStimulus(0);
    waitDone(0, 0, 100, n);
    checkOutput("ori_cycles", n, 22);
    checkOutput("ori_fail_count", failCountA, 4'd1);
    checkOutput("ori_first_fail", firstFailA, 4'd7);
    checkOutput("ori_fail_bits", failBitsA, 15'h0008);
    checkOutput("ori_pass", passA, 1'b0);

    // alu_op stuck at 11: every vector but R-type fails; start in DONE clears.
    $display("[TB] alu_op stuck-at-11 run");
    faultMode = 2'd2;
    applyStimulus(0);
    checkOutput("restart_fail_count_clr", failCountA, 4'd0);
    checkOutput("restart_first_fail_clr", firstFailA, 4'hF);
    checkOutput("restart_fail_bits_clr", failBitsA, 15'h0000);
    waitDone(0, 0, 100, n);
    checkOutput("alu_cycles", n, 22);
    checkOutput("alu_fail_count", failCountA, 4'd10);
    checkOutput("alu_first_fail", firstFailA, 4'd1);
    checkOutput("alu_fail_bits", failBitsA, 15'h0003);
    checkOutput("alu_pass", passA, 1'b0);

    // start re-pulsed while in WAIT must not restart the run.
    $display("[TB] start ignored while busy");
    faultMode = 2'd0;
    applyStimulus(0);
    tick();
    tick();
    startA = 1'b1;
    tick();
    startA = 1'b0;
    checkOutput("repulse_opcode", opA, vecOps[1]);
    waitDone(0, 3, 100, n);
    checkOutput("repulse_cycles", n, 22);
    checkOutput("repulse_pass", passA, 1'b1);

    // Asynchronous reset in the middle of vector 5.
    $display("[TB] reset mid-run");
    faultMode = 2'd2;
    applyStimulus(0);
    repeat (11) tick();
    checkOutput("mid_opcode", opA, vecOps[5]);
    checkOutput("mid_fail_count", failCountA, 4'd4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_opcode", opA, 6'b000000);
    checkOutput("arst_busy", busyA, 1'b0);
    checkOutput("arst_done", doneA, 1'b0);
    checkOutput("arst_pass", passA, 1'b0);
    checkOutput("arst_fail_count", failCountA, 4'd0);
    checkOutput("arst_first_fail", firstFailA, 4'hF);
    checkOutput("arst_fail_bits", failBitsA, 15'h0000);
    #2;
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("post_rst_busy", busyA, 1'b0);
    checkOutput("post_rst_opcode", opA, 6'b000000);
    faultMode = 2'd0;
    applyStimulus(0);
    waitDone(0, 0, 100, n);
    checkOutput("post_rst_cycles", n, 22);
    checkOutput("post_rst_pass", passA, 1'b1);

    // SETTLE=4 covers the 3-cycle decoder latency.
    $display("[TB] SETTLE=4 with latent decoder");
    applyStimulus(1);
    waitDone(1, 0, 200, n);
    checkOutput("s4_cycles", n, 55);
    checkOutput("s4_pass", passB, 1'b1);
    checkOutput("s4_fail_count", failCountB, 4'd0);
    checkOutput("s4_first_fail", firstFailB, 4'hF);

    // SETTLE=2 samples one vector late. After reset the stale word matches
    // vector 0; after a prior run it is the unsupported word, so vector 0 fails.
    $display("[TB] SETTLE=2 with latent decoder");
    applyStimulus(2);
    waitDone(2, 0, 200, n);
    checkOutput("s2a_cycles", n, 33);
    checkOutput("s2a_pass", passC, 1'b0);
    checkOutput("s2a_fail_count", failCountC, 4'd10);
    checkOutput("s2a_first_fail", firstFailC, 4'd1);
    applyStimulus(2);
    waitDone(2, 0, 200, n);
    checkOutput("s2b_cycles", n, 33);
    checkOutput("s2b_pass", passC, 1'b0);
    checkOutput("s2b_fail_count", failCountC, 4'd11);
    checkOutput("s2b_first_fail", firstFailC, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controller_bist.md
# controller_bist

Built-in self-test driver for the `big_controller` main decoder. On `start` it steps the decoder's `opcode` input through a fixed 11-entry vector table and samples the decoder's 15 control outputs after a programmable settle delay. Each sample is compared against a golden control word, and the block reports mismatch count, first failing index and an accumulated bit-error mask. It sits beside the decoder in the CPU top level and drives the decoder's opcode input whenever the test mux selects BIST mode.

## Interface
- `SETTLE`, 1: cycles from an opcode change to the sample point; legal range 1..15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; only honoured in IDLE or DONE.
- `ctrl_word`  in  15  decoder outputs, packed MSB→LSB: {r_type, alu_src, mem_to_reg, reg_write, reg_write2, mem_read, mem_write, j, jal, beq, bne, ori, lui, alu_op[1:0]}.
- `opcode`  out  6  opcode driven to the decoder.
- `busy`  out  1  high in WAIT or CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `fail_count`==0.
- `fail_count`  out  4  number of mismatching vectors in the current or last run.
- `first_fail_idx`  out  4  vector index of the first mismatch; 4'hF if none.
- `fail_bits`  out  15  OR-accumulation of (`ctrl_word` ^ golden) over the run.

## Operation
- Vector table, index: opcode → golden word (set bits only, all others 0; alu_op given explicitly):
  - 0: 000000 R-type → r_type, reg_write, reg_write2, alu_op=11.
  - 1: 100011 lw → alu_src, mem_to_reg, reg_write, mem_read, alu_op=00.
  - 2: 101011 sw → alu_src, mem_write, alu_op=00.
  - 3: 000100 beq → beq, alu_op=01.
  - 4: 000101 bne → bne, alu_op=01.
  - 5: 000010 j → j, alu_op=00.
  - 6: 000011 jal → jal, reg_write, alu_op=00.
  - 7: 001101 ori → alu_src, reg_write, ori, alu_op=10.
  - 8: 001111 lui → alu_src, reg_write, lui, alu_op=00.
  - 9: 001000 addi → alu_src, reg_write, alu_op=00.
  - 10: 111111 unsupported → all 15 bits 0.
- FSM states: IDLE, WAIT, CHECK, DONE.
  - IDLE/DONE, `start`=1: clear `fail_count`, `fail_bits`, set `first_fail_idx`=F, idx=0, `opcode`←vec[0], wait counter←SETTLE, go to WAIT.
  - WAIT: decrement the counter each cycle; when it reaches 1, go to CHECK.
  - CHECK: compare `ctrl_word` with golden[idx].
    - On mismatch: `fail_count`+1, OR the XOR into `fail_bits`, and latch idx into `first_fail_idx` if it is still F.
    - If idx==10, go to DONE and hold `opcode`.
    - Otherwise idx+1, `opcode`←vec[idx+1], counter←SETTLE, go to WAIT.
  - DONE: hold all results until the next `start`.
- `start` in WAIT/CHECK is ignored.
- Maximum `fail_count` is 11, so 4 bits never overflow.

## Timing
- Reset (asynchronous, any state): state=IDLE, `opcode`=000000, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail_idx`=F, `fail_bits`=0.
- Edge E0 samples `start`=1, and `opcode`=vec[0] appears after E0.
- Each vector occupies SETTLE+1 cycles. Vector k is sampled at edge E0+(k+1)(SETTLE+1).
- `done` rises after edge E0+11(SETTLE+1), which is 22 cycles for SETTLE=1.
- Results (`fail_count`, `fail_bits`, `first_fail_idx`) update on the CHECK edge, so they are visible one cycle after that edge.
- `pass` is combinational: (state==DONE) && (`fail_count`==0).
- `rst_n` deasserted mid-run aborts the run: outputs return to reset values immediately, and no further action occurs until `start`.

## Test plan
- Golden decoder, SETTLE=1, single `start` pulse → `done` rises 22 cycles later; `pass`=1, `fail_count`=0, `first_fail_idx`=F, `fail_bits`=0; `opcode` sequence matches table order, each value held 2 cycles.
- Decoder with `ori` forced to 0 → `fail_count`=1, `first_fail_idx`=7, `fail_bits`=15'h0008 (ori bit), `pass`=0.
- Decoder with alu_op stuck at 11 → mismatches at indexes 1–10 except 0; `fail_count`=10, `first_fail_idx`=1, `fail_bits`=15'h0003.
- SETTLE=4 with a decoder whose outputs are registered with 3 cycles of latency → `pass`=1. With SETTLE=2 → `pass`=0, `first_fail_idx`=0.
- `start` re-pulsed during WAIT → no restart, completion time unchanged. `start` in DONE → counters clear and a new run completes after 22 cycles.
- `rst_n` pulsed low at vector 5 → all outputs return to reset values asynchronously. A subsequent `start` runs cleanly to `pass`=1.
